// File: rtl/ctr_drbg_generate.sv
// rtl/ctr_drbg_generate.sv - CTR_DRBG (AES-256) generate stage driving an external AES core
// Optional feature macro: CTR_DRBG_ADDIN_EN (additional-input update before generation)
module ctr_drbg_generate #(
    parameter int          MAX_BLOCKS      = 16,
    parameter logic [31:0] RESEED_INTERVAL = 32'd4096,
    parameter int          NB_W            = $clog2(MAX_BLOCKS + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [NB_W-1:0] num_blocks,
    input  logic [383:0]    additional_input,
    input  logic [255:0]    key_in,
    input  logic [127:0]    v_in,
    input  logic [31:0]     reseed_counter_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [127:0]    out_block,
    output logic            aes_req,
    input  logic            aes_ack,
    output logic [255:0]    aes_key,
    output logic [127:0]    aes_pt,
    input  logic [127:0]    aes_ct,
    output logic [255:0]    key_out,
    output logic [127:0]    v_out,
    output logic [31:0]     reseed_counter_out,
    output logic            busy,
    output logic            done,
    output logic            reseed_required
);

`ifdef CTR_DRBG_ADDIN_EN
    localparam bit ADDIN_EN = 1'b1;
`else
    localparam bit ADDIN_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, ADD_UPD, GEN_ENC, GEN_OUT, FIN_UPD, DONE} state_t;

    state_t          state;
    logic [255:0]    key_r;
    logic [127:0]    v_r;
    logic [383:0]    addin_r;
    logic [31:0]     rc_r;
    logic [NB_W-1:0] blocks_left;
    logic [1:0]      op_cnt;
    logic [255:0]    tmp_r;
    logic [NB_W-1:0] nb_clamped;
    logic            addin_nz;
    logic [383:0]    upd_data;
    logic [383:0]    upd_temp;

    assign nb_clamped = (num_blocks > NB_W'(MAX_BLOCKS)) ? NB_W'(MAX_BLOCKS) : num_blocks;
    assign addin_nz   = ADDIN_EN && (additional_input != '0);
    assign upd_data   = addin_r & {384{ADDIN_EN}};
    // ct1/ct2 are held in tmp_r; ct3 is taken straight off the bus on the final ack
    assign upd_temp   = {tmp_r, aes_ct} ^ upd_data;

    // V only moves when a request is launched, so it doubles as the stable plaintext
    assign aes_key = key_r;
    assign aes_pt  = v_r;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            key_r              <= '0;
            v_r                <= '0;
            addin_r            <= '0;
            rc_r               <= '0;
            blocks_left        <= '0;
            op_cnt             <= '0;
            tmp_r              <= '0;
            out_valid          <= 1'b0;
            out_block          <= '0;
            aes_req            <= 1'b0;
            key_out            <= '0;
            v_out              <= '0;
            reseed_counter_out <= '0;
            done               <= 1'b0;
            reseed_required    <= 1'b0;
        end else begin
            done            <= 1'b0;
            reseed_required <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (reseed_counter_in > RESEED_INTERVAL) begin
                            done            <= 1'b1;
                            reseed_required <= 1'b1;
                            state           <= DONE;
                        end else begin
                            key_r       <= key_in;
                            v_r         <= v_in;
                            addin_r     <= additional_input;
                            rc_r        <= reseed_counter_in;
                            blocks_left <= nb_clamped;
                            op_cnt      <= '0;
                            if (addin_nz)
                                state <= ADD_UPD;
                            else if (nb_clamped != '0)
                                state <= GEN_ENC;
                            else
                                state <= FIN_UPD;
                        end
                    end
                end
                ADD_UPD, FIN_UPD: begin
                    if (!aes_req) begin
                        v_r     <= v_r + 128'd1;
                        aes_req <= 1'b1;
                    end else if (aes_ack) begin
                        aes_req <= 1'b0;
                        case (op_cnt)
                            2'd0: tmp_r[255:128] <= aes_ct;
                            2'd1: tmp_r[127:0]   <= aes_ct;
                            default: begin
                                key_r <= upd_temp[383:128];
                                v_r   <= upd_temp[127:0];
                                if (state == FIN_UPD) begin
                                    key_out            <= upd_temp[383:128];
                                    v_out              <= upd_temp[127:0];
                                    reseed_counter_out <= rc_r + 32'd1;
                                    done               <= 1'b1;
                                    state              <= DONE;
                                end else begin
                                    state <= (blocks_left != '0) ? GEN_ENC : FIN_UPD;
                                end
                            end
                        endcase
                        op_cnt <= (op_cnt == 2'd2) ? 2'd0 : op_cnt + 2'd1;
                    end
                end
                GEN_ENC: begin
                    if (!aes_req) begin
                        v_r     <= v_r + 128'd1;
                        aes_req <= 1'b1;
                    end else if (aes_ack) begin
                        aes_req   <= 1'b0;
                        out_block <= aes_ct;
                        out_valid <= 1'b1;
                        state     <= GEN_OUT;
                    end
                end
                GEN_OUT: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        blocks_left <= blocks_left - NB_W'(1);
                        state       <= (blocks_left != NB_W'(1)) ? GEN_ENC : FIN_UPD;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctr_drbg_generate.sv
// tb/tb_ctr_drbg_generate.sv - scoreboard bench for ctr_drbg_generate with behavioural AES responder
module tb_ctr_drbg_generate;
    localparam int          NB_W = 5;
    localparam logic [31:0] RI   = 32'd4096;
`ifdef CTR_DRBG_ADDIN_EN
    localparam bit ADDIN = 1'b1;
`else
    localparam bit ADDIN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [NB_W-1:0] num_blocks;
    logic [383:0]    additional_input;
    logic [255:0]    key_in;
    logic [127:0]    v_in;
    logic [31:0]     reseed_counter_in;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [127:0]    out_block;
    logic            aes_req;
    logic            aes_ack;
    logic [255:0]    aes_key;
    logic [127:0]    aes_pt;
    logic [127:0]    aes_ct;
    logic [255:0]    key_out;
    logic [127:0]    v_out;
    logic [31:0]     reseed_counter_out;
    logic            busy;
    logic            done;
    logic            reseed_required;

    ctr_drbg_generate dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_blocks(num_blocks),
        .additional_input(additional_input), .key_in(key_in), .v_in(v_in),
        .reseed_counter_in(reseed_counter_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_block(out_block), .aes_req(aes_req), .aes_ack(aes_ack), .aes_key(aes_key),
        .aes_pt(aes_pt), .aes_ct(aes_ct), .key_out(key_out), .v_out(v_out),
        .reseed_counter_out(reseed_counter_out), .busy(busy), .done(done),
        .reseed_required(reseed_required)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           refused;
        logic [255:0] key;
        logic [127:0] v;
        logic [31:0]  rc;
        int           nops;
    } done_t;

    int           checks = 0;
    int           errors = 0;
    logic [127:0] exp_q[$];
    logic [127:0] exp_pts[$];
    done_t        done_q[$];
    logic [127:0] op_pts[$];
    logic [255:0] com_key;
    logic [127:0] com_v;
    logic [31:0]  com_rc;
    int           done_seen = 0;
    int           ready_pct = 100;

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stand-in block cipher: only needs to be a deterministic, key-dependent mixing function
    function automatic logic [127:0] aes_model(input logic [255:0] k, input logic [127:0] p);
        logic [127:0] x;
        x = p ^ k[127:0];
        x = x * 128'h9e3779b97f4a7c15f39cc0605cedc835 + k[255:128];
        x = {x[86:0], x[127:87]} ^ (x >> 3);
        return x;
    endfunction

    function automatic void model_upd(inout logic [255:0] k, inout logic [127:0] v,
                                      input logic [383:0] d);
        logic [127:0] ct [3];
        for (int i = 0; i < 3; i++) begin
            v = v + 128'd1;
            exp_pts.push_back(v);
            ct[i] = aes_model(k, v);
        end
        {k, v} = {ct[0], ct[1], ct[2]} ^ d;
    endfunction

    task automatic issue_txn(input logic [255:0] k, input logic [127:0] v, input logic [383:0] a,
                             input logic [NB_W-1:0] nb, input logic [31:0] rc);
        done_t        d;
        int           n;
        int           n0;
        logic [255:0] mk;
        logic [127:0] mv;
        logic [383:0] data;
        n0 = exp_pts.size();
        if (rc > RI) begin
            d = '{1'b1, com_key, com_v, com_rc, 0};
        end else begin
            mk   = k;
            mv   = v;
            data = ADDIN ? a : '0;
            n    = (nb > 16) ? 16 : int'(nb);
            if (data != '0) model_upd(mk, mv, data);
            for (int i = 0; i < n; i++) begin
                mv = mv + 128'd1;
                exp_pts.push_back(mv);
                exp_q.push_back(aes_model(mk, mv));
            end
            model_upd(mk, mv, data);
            com_key = mk;
            com_v   = mv;
            com_rc  = rc + 32'd1;
            d = '{1'b0, mk, mv, com_rc, exp_pts.size() - n0};
        end
        done_q.push_back(d);
        @(negedge clk);
        start = 1'b1; key_in = k; v_in = v; additional_input = a;
        num_blocks = nb; reseed_counter_in = rc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic flush_model();
        exp_q.delete(); exp_pts.delete(); done_q.delete(); op_pts.delete();
        com_key = '0; com_v = '0; com_rc = '0;
    endtask

    task automatic wait_done(input bit poke);
        int start_seen;
        int cyc;
        bit poked;
        start_seen = done_seen;
        cyc = 0;
        poked = 1'b0;
        while (done_seen == start_seen && cyc < 3000) begin
            @(negedge clk); #3;
            cyc++;
            if (poke && !poked && busy && done_seen == start_seen && $urandom_range(0, 9) == 0) begin
                start = 1'b1;
                reseed_counter_in = $urandom_range(0, 100);
                num_blocks = 5'd3;
                @(negedge clk);
                start = 1'b0;
                poked = 1'b1;
            end
        end
        if (done_seen == start_seen) begin
            checks++; errors++;
            $display("FAIL done_timeout: no done after %0d cycles, required a done pulse", cyc);
            rst_n = 1'b0;
            #1 flush_model();
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            @(negedge clk); #3;
            check("busy_after_done", busy, 0);
        end
    endtask

    // AES responder: random 1..4 cycle latency, occasional ack pulse while aes_req is low
    int           lat = -1;
    bit           spur = 1'b0;
    logic [127:0] cur_pt;
    logic [255:0] cur_key;
    initial begin
        aes_ack = 1'b0;
        aes_ct  = '0;
        forever begin
            @(negedge clk);
            aes_ack = 1'b0;
            if (!rst_n) begin
                lat  = -1;
                spur = 1'b0;
            end else if (spur && !aes_req) begin
                spur    = 1'b0;
                aes_ack = 1'b1;
                aes_ct  = {4{$urandom}};
            end else if (aes_req) begin
                spur = 1'b0;
                if (lat < 0) begin
                    lat     = $urandom_range(1, 4);
                    cur_pt  = aes_pt;
                    cur_key = aes_key;
                    op_pts.push_back(aes_pt);
                end
                lat--;
                if (lat == 0) begin
                    check("aes_stable", {aes_key, aes_pt}, {cur_key, cur_pt});
                    aes_ack = 1'b1;
                    aes_ct  = aes_model(aes_key, aes_pt);
                    lat     = -1;
                    spur    = ($urandom_range(0, 3) == 0);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (ready_pct >= 0) out_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Monitor: pops expected blocks on each accept and expected state on each done
    initial begin
        bit           prev_wait;
        logic [127:0] prev_blk;
        logic [127:0] e;
        done_t        d;
        prev_wait = 1'b0;
        prev_blk  = '0;
        forever begin
            @(negedge clk); #2;
            if (!rst_n) begin
                prev_wait = 1'b0;
            end else begin
                if (prev_wait) check("out_hold", {out_valid, out_block}, {1'b1, prev_blk});
                prev_wait = out_valid && !out_ready;
                prev_blk  = out_block;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_block: got %0h, required no block", out_block);
                    end else begin
                        check("out_block", out_block, exp_q.pop_front());
                    end
                end
                if (done || reseed_required) begin
                    if (done_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: done=%0b reseed_required=%0b, required none",
                                 done, reseed_required);
                    end else begin
                        d = done_q.pop_front();
                        check("done_flags", {done, reseed_required}, {1'b1, d.refused});
                        check("key_out", key_out, d.key);
                        check("v_out", v_out, d.v);
                        check("reseed_counter_out", reseed_counter_out, d.rc);
                        check("blocks_pending_at_done", exp_q.size(), 0);
                        check("aes_op_count", op_pts.size(), d.nops);
                        for (int i = 0; i < d.nops; i++) begin
                            e = (exp_pts.size() > 0) ? exp_pts.pop_front() : '0;
                            if (i < op_pts.size()) check("aes_pt", op_pts[i], e);
                        end
                        op_pts.delete();
                        done_seen++;
                    end
                end
            end
        end
    end

    initial begin
        int           cyc;
        logic [255:0] rk;
        logic [127:0] rv;
        logic [383:0] ra;
        logic [31:0]  rrc;
        rst_n = 1'b0; start = 1'b0; num_blocks = '0; additional_input = '0;
        key_in = '0; v_in = '0; reseed_counter_in = '0;
        flush_model();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", {done, reseed_required}, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_aes_req", aes_req, 0);
        check("rst_out_block", out_block, 0);
        check("rst_state_out", {key_out, v_out}, 0);
        check("rst_rc_out", reseed_counter_out, 0);
        rst_n = 1'b1;

        issue_txn('0, '0, '0, 5'd2, 32'd1);
        wait_done(1'b0);
        issue_txn({8{$urandom}}, '1, '0, 5'd1, 32'd5);
        wait_done(1'b0);
        issue_txn({8{$urandom}}, {4{$urandom}}, {12{$urandom}}, 5'd3, RI + 32'd1);
        wait_done(1'b0);
        issue_txn({8{$urandom}}, {4{$urandom}}, '0, 5'd1, RI);
        wait_done(1'b0);

        ready_pct = -1;
        out_ready = 1'b0;
        issue_txn({8{$urandom}}, {4{$urandom}}, '0, 5'd1, 32'd7);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("stall_valid_seen", out_valid, 1);
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        wait_done(1'b0);
        ready_pct = 100;

        issue_txn({8{$urandom}}, {4{$urandom}}, 384'h1, 5'd2, 32'd9);
        wait_done(1'b0);
        issue_txn({8{$urandom}}, {4{$urandom}}, {12{$urandom}}, 5'd20, 32'd11);
        wait_done(1'b0);
        issue_txn({8{$urandom}}, {4{$urandom}}, {12{$urandom}}, 5'd0, 32'hFFFF_FFFF);
        wait_done(1'b0);
        issue_txn({8{$urandom}}, {4{$urandom}}, {12{$urandom}}, 5'd0, 32'd0);
        wait_done(1'b0);

        issue_txn('0, '0, '0, 5'd2, 32'd1);
        cyc = 0;
        while (!aes_req && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_req_seen", aes_req, 1);
        #3 rst_n = 1'b0;
        #1;
        check("abort_aes_req", aes_req, 0);
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_key_out", key_out, 0);
        flush_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);

        for (int t = 0; t < 40; t++) begin
            ready_pct = $urandom_range(30, 100);
            rk = {8{$urandom}};
            rv = ($urandom_range(0, 3) == 0) ? ('1 - 128'($urandom_range(0, 3))) : {4{$urandom}};
            case ($urandom_range(0, 2))
                0:       ra = '0;
                1:       ra = 384'h1;
                default: ra = {12{$urandom}};
            endcase
            case ($urandom_range(0, 9))
                0:       rrc = RI + 32'd1 + 32'($urandom_range(0, 1000));
                1:       rrc = 32'hFFFF_FFFF;
                2:       rrc = RI;
                default: rrc = 32'($urandom_range(0, 4096));
            endcase
            issue_txn(rk, rv, ra, 5'($urandom_range(0, 20)), rrc);
            wait_done(1'b1);
        end
        repeat (10) @(negedge clk);
        check("final_blocks_drained", exp_q.size(), 0);
        check("final_done_drained", done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
